// File: rtl/xdisp_driver_pkg.sv
// Shared types, symbol codes and field encodings for the 4-digit display driver.
// Also holds the double-dabble (shift-add-3) step used for binary-to-BCD conversion.
package xdisp_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT
  } state_t;

  // Symbol codes understood by the segment encoder; 0..9 are the decimal digits.
  localparam logic [4:0] SYM_DASH  = 5'd10;
  localparam logic [4:0] SYM_O     = 5'd11;
  localparam logic [4:0] SYM_P     = 5'd12;
  localparam logic [4:0] SYM_U     = 5'd13;
  localparam logic [4:0] SYM_A     = 5'd14;
  localparam logic [4:0] SYM_L     = 5'd15;
  localparam logic [4:0] SYM_E     = 5'd16;
  localparam logic [4:0] SYM_R     = 5'd17;
  localparam logic [4:0] SYM_BLANK = 5'd18;

  localparam logic [1:0] MSG_NUM = 2'b00;
  localparam logic [1:0] MSG_OP  = 2'b01;
  localparam logic [1:0] MSG_VAL = 2'b10;
  localparam logic [1:0] MSG_ERR = 2'b11;

  localparam logic [1:0] DOT_D1 = 2'b01;
  localparam logic [1:0] DOT_D2 = 2'b10;

  typedef struct packed {
    logic [4:0] sym;
    logic       dp;
  } digit_t;

  localparam digit_t DIGIT_BLANK = '{sym: SYM_BLANK, dp: 1'b0};

  // One iteration on {bcd[11:0], bin[7:0]}: correct each BCD nibble, then shift left.
  function automatic logic [19:0] dabble_step(input logic [19:0] x);
    logic [19:0] y;
    y = x;
    for (int i = 0; i < 3; i++) begin
      if (y[8+4*i +: 4] >= 4'd5) y[8+4*i +: 4] = y[8+4*i +: 4] + 4'd3;
    end
    return {y[18:0], 1'b0};
  endfunction

endpackage

// File: rtl/xdisp_driver_if.sv
// Register-bus port group of the display driver: select, write strobe, data in and status out.
interface xdisp_driver_if #(
  parameter int DATA_W = 32
);
  logic              sel;
  logic              we;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;

  modport master (output sel, we, data_in, input data_out);
  modport slave  (input sel, we, data_in, output data_out);
endinterface

// File: rtl/xdisp_driver_seg.sv
// Segment encoder: symbol code plus decimal point to active-low segments {dp, g..a}.
module xdisp_driver_seg
  import xdisp_driver_pkg::*;
(
  input  logic [4:0] sym,
  input  logic       dp,
  output logic [7:0] seg
);

  logic [6:0] body;

  always_comb begin
    body = 7'h7F;
    unique case (sym)
      5'd0:      body = 7'h40;
      5'd1:      body = 7'h79;
      5'd2:      body = 7'h24;
      5'd3:      body = 7'h30;
      5'd4:      body = 7'h19;
      5'd5:      body = 7'h12;
      5'd6:      body = 7'h02;
      5'd7:      body = 7'h78;
      5'd8:      body = 7'h00;
      5'd9:      body = 7'h10;
      SYM_DASH:  body = 7'h3F;
      SYM_O:     body = 7'h40;
      SYM_P:     body = 7'h0C;
      SYM_U:     body = 7'h41;
      SYM_A:     body = 7'h08;
      SYM_L:     body = 7'h47;
      SYM_E:     body = 7'h06;
      SYM_R:     body = 7'h2F;
      default:   body = 7'h7F;
    endcase
  end

  assign seg = {~dp, body};

endmodule

// File: rtl/xdisp_driver.sv
// 4-digit multiplexed 7-segment driver: written value is BCD-converted, committed
// atomically, then scanned out one digit per REFRESH_DIV cycles.
module xdisp_driver
  import xdisp_driver_pkg::*;
#(
  parameter int REFRESH_DIV = 65536,
  parameter int DATA_W      = 32
) (
  input  logic            clk,
  input  logic            rst,
  xdisp_driver_if.slave   bus,
  output logic [7:0]      disp_value,
  output logic [3:0]      disp_select
);

  localparam int             CW        = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0]  SCAN_LAST = CW'(REFRESH_DIV - 1);

  state_t      state, state_nxt;
  logic        wr;
  logic [2:0]  shift_cnt;
  logic [19:0] dd;
  logic        sign_q;
  logic [1:0]  msg_q, dot_q;
  logic        done;
  digit_t      digits   [4];
  digit_t      digits_nxt [4];
  logic [CW-1:0] scan_cnt;
  logic [1:0]  idx;
  logic [7:0]  seg_out;
  logic        unused_data;

  assign wr          = bus.sel & bus.we;
  assign unused_data = ^bus.data_in[DATA_W-1:13];
  assign bus.data_out = DATA_W'({done, state != ST_IDLE});

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // A write in any state (re)starts the conversion, which is what makes aborts cheap.
  always_comb begin
    state_nxt = state;
    if (wr) begin
      state_nxt = ST_SHIFT;
    end else begin
      unique case (state)
        ST_IDLE:   state_nxt = ST_IDLE;
        ST_SHIFT:  if (shift_cnt == 3'd0) state_nxt = ST_COMMIT;
        ST_COMMIT: state_nxt = ST_IDLE;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) digits_nxt[i] = DIGIT_BLANK;
    unique case (msg_q)
      MSG_NUM: begin
        digits_nxt[0].sym = {1'b0, dd[11:8]};
        if (dd[19:16] != 4'd0) digits_nxt[2].sym = {1'b0, dd[19:16]};
        if (dd[19:12] != 8'd0) digits_nxt[1].sym = {1'b0, dd[15:12]};
        if (sign_q) digits_nxt[3].sym = SYM_DASH;
      end
      MSG_OP: begin
        digits_nxt[1].sym = SYM_O;
        digits_nxt[0].sym = SYM_P;
      end
      MSG_VAL: begin
        digits_nxt[2].sym = SYM_U;
        digits_nxt[1].sym = SYM_A;
        digits_nxt[0].sym = SYM_L;
      end
      default: begin
        digits_nxt[2].sym = SYM_E;
        digits_nxt[1].sym = SYM_R;
        digits_nxt[0].sym = SYM_R;
      end
    endcase
    digits_nxt[1].dp = (dot_q == DOT_D1);
    digits_nxt[2].dp = (dot_q == DOT_D2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dd        <= '0;
      shift_cnt <= '0;
      sign_q    <= 1'b0;
      msg_q     <= MSG_NUM;
      dot_q     <= 2'b00;
      done      <= 1'b0;
      for (int i = 0; i < 4; i++) digits[i] <= DIGIT_BLANK;
    end else if (wr) begin
      dd        <= {12'd0, bus.data_in[7:0]};
      shift_cnt <= 3'd7;
      sign_q    <= bus.data_in[8];
      msg_q     <= bus.data_in[10:9];
      dot_q     <= bus.data_in[12:11];
      done      <= 1'b0;
    end else begin
      unique case (state)
        ST_SHIFT: begin
          dd        <= dabble_step(dd);
          shift_cnt <= shift_cnt - 3'd1;
        end
        ST_COMMIT: begin
          for (int i = 0; i < 4; i++) digits[i] <= digits_nxt[i];
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  xdisp_driver_seg u_seg (
    .sym (digits[idx].sym),
    .dp  (digits[idx].dp),
    .seg (seg_out)
  );

  // Outputs lag idx by one cycle uniformly, so every digit still gets exactly REFRESH_DIV cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt    <= '0;
      idx         <= 2'd0;
      disp_select <= 4'b1110;
      disp_value  <= 8'hFF;
    end else begin
      disp_select <= ~(4'b0001 << idx);
      disp_value  <= seg_out;
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        idx      <= idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + CW'(1);
      end
    end
  end

endmodule
